// File: rtl/mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_sched
// Brief    : In-order scheduler issuing up to two buffered memory ops per cycle
//            onto a dual-port BRAM. Macro MEM_SCHED_FWD_EN enables co-issue of
//            a store and a younger load to the same address (iss_fwd).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef AL_SIZE
`define AL_SIZE 8
`endif

module mem_sched #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int AL_W   = $clog2(`AL_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  enq_valid,
  output logic                        enq_ready,
  input  logic [1:0]                  enq_is_store,
  input  logic [1:0][ADDR_W-1:0]      enq_addr,
  input  logic [1:0][31:0]            enq_data,
  input  logic [1:0][4:0]             enq_rd,
  input  logic [1:0][AL_W-1:0]        enq_al_idx,
  input  logic                        if_recall,
  input  logic [AL_W-1:0]             new_front,
  input  logic [AL_W-1:0]             back,
  output logic [1:0]                  iss_valid,
  output logic [1:0]                  iss_we,
  output logic [1:0][9:0]             iss_addr,
  output logic [1:0][31:0]            iss_data,
  output logic [1:0][4:0]             iss_rd,
  output logic [1:0][AL_W-1:0]        iss_al_idx,
  output logic [1:0]                  iss_uses_rd,
  output logic                        iss_fwd,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              r_is_store [DEPTH];
  logic [ADDR_W-1:0] r_addr     [DEPTH];
  logic [31:0]       r_data     [DEPTH];
  logic [4:0]        r_rd       [DEPTH];
  logic [AL_W-1:0]   r_al       [DEPTH];

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_a, w_b, w_slot1;
  logic          w_same, w_b_ok, w_fwd, w_iss_a, w_iss_b, w_do_enq, w_found;
  logic [1:0]    w_iss_n, w_enq_n;
  logic [CW-1:0] w_keep;

  function automatic logic in_window(input logic [AL_W-1:0] idx,
                                     input logic [AL_W-1:0] lo,
                                     input logic [AL_W-1:0] hi);
    if (lo <= hi) return (idx >= lo) && (idx < hi);
    return (idx >= lo) || (idx < hi);
  endfunction

  assign occupancy = r_count;
  assign enq_ready = (r_count <= CW'(DEPTH - 2));

  assign w_a    = r_head;
  assign w_b    = r_head + PW'(1);
  assign w_same = (r_addr[w_a] == r_addr[w_b]);

`ifdef MEM_SCHED_FWD_EN
  logic w_fwd_pair;
  assign w_fwd_pair = r_is_store[w_a] && !r_is_store[w_b] && w_same;
  assign w_b_ok     = !w_same || w_fwd_pair;
  assign w_fwd      = w_iss_b && w_fwd_pair;
`else
  assign w_b_ok = !w_same;
  assign w_fwd  = 1'b0;
`endif

  assign w_iss_a  = !if_recall && (r_count != '0);
  assign w_iss_b  = w_iss_a && (r_count >= CW'(2)) && w_b_ok;
  assign w_iss_n  = {1'b0, w_iss_a} + {1'b0, w_iss_b};
  assign w_do_enq = enq_ready && !if_recall;
  assign w_enq_n  = w_do_enq ? ({1'b0, enq_valid[0]} + {1'b0, enq_valid[1]}) : 2'd0;
  // A lone slot-1 request lands at tail.
  assign w_slot1  = r_tail + PW'(enq_valid[0]);

  // Squashed entries form a suffix: keep everything older than the first hit.
  always_comb begin
    w_keep  = r_count;
    w_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_found && (CW'(k) < r_count) &&
          in_window(r_al[r_head + PW'(k)], new_front, back)) begin
        w_found = 1'b1;
        w_keep  = CW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq && enq_valid[0]) begin
      r_is_store[r_tail] <= enq_is_store[0];
      r_addr[r_tail]     <= enq_addr[0];
      r_data[r_tail]     <= enq_data[0];
      r_rd[r_tail]       <= enq_rd[0];
      r_al[r_tail]       <= enq_al_idx[0];
    end
    if (w_do_enq && enq_valid[1]) begin
      r_is_store[w_slot1] <= enq_is_store[1];
      r_addr[w_slot1]     <= enq_addr[1];
      r_data[w_slot1]     <= enq_data[1];
      r_rd[w_slot1]       <= enq_rd[1];
      r_al[w_slot1]       <= enq_al_idx[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      iss_valid   <= '0;
      iss_we      <= '0;
      iss_addr    <= '0;
      iss_data    <= '0;
      iss_rd      <= '0;
      iss_al_idx  <= '0;
      iss_uses_rd <= '0;
      iss_fwd     <= 1'b0;
    end else begin
      if (if_recall) begin
        r_tail  <= r_head + w_keep[PW-1:0];
        r_count <= w_keep;
      end else begin
        r_head  <= r_head + PW'(w_iss_n);
        r_tail  <= r_tail + PW'(w_enq_n);
        r_count <= r_count + CW'(w_enq_n) - CW'(w_iss_n);
      end
      iss_valid      <= {w_iss_b, w_iss_a};
      iss_we[0]      <= w_iss_a && r_is_store[w_a];
      iss_we[1]      <= w_iss_b && r_is_store[w_b];
      iss_uses_rd[0] <= w_iss_a && !r_is_store[w_a];
      iss_uses_rd[1] <= w_iss_b && !r_is_store[w_b];
      iss_addr[0]    <= r_addr[w_a][9:0];
      iss_addr[1]    <= r_addr[w_b][9:0];
      iss_data[0]    <= r_data[w_a];
      iss_data[1]    <= r_data[w_b];
      iss_rd[0]      <= r_rd[w_a];
      iss_rd[1]      <= r_rd[w_b];
      iss_al_idx[0]  <= r_al[w_a];
      iss_al_idx[1]  <= r_al[w_b];
      iss_fwd        <= w_fwd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sched
// Brief    : Self-checking bench for mem_sched: pair-hazard vector table,
//            issue-order scoreboard, reset, ready and recall sequences.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_sched;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int AL_W   = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [1:0]             enq_valid = '0;
  logic                   enq_ready;
  logic [1:0]             enq_is_store = '0;
  logic [1:0][ADDR_W-1:0] enq_addr = '0;
  logic [1:0][31:0]       enq_data = '0;
  logic [1:0][4:0]        enq_rd = '0;
  logic [1:0][AL_W-1:0]   enq_al_idx = '0;
  logic                   if_recall = 1'b0;
  logic [AL_W-1:0]        new_front = '0;
  logic [AL_W-1:0]        back = '0;
  logic [1:0]             iss_valid;
  logic [1:0]             iss_we;
  logic [1:0][9:0]        iss_addr;
  logic [1:0][31:0]       iss_data;
  logic [1:0][4:0]        iss_rd;
  logic [1:0][AL_W-1:0]   iss_al_idx;
  logic [1:0]             iss_uses_rd;
  logic                   iss_fwd;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  mem_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AL_W(AL_W)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
    .enq_addr(enq_addr), .enq_data(enq_data), .enq_rd(enq_rd), .enq_al_idx(enq_al_idx),
    .if_recall(if_recall), .new_front(new_front), .back(back),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_addr(iss_addr), .iss_data(iss_data),
    .iss_rd(iss_rd), .iss_al_idx(iss_al_idx), .iss_uses_rd(iss_uses_rd),
    .iss_fwd(iss_fwd), .occupancy(occupancy)
  );

  typedef struct {
    logic            we;
    logic [9:0]      addr;
    logic [31:0]     data;
    logic [4:0]      rd;
    logic [AL_W-1:0] al;
  } exp_t;

  typedef struct {
    string       name;
    logic        st0;
    logic [31:0] a0;
    logic        st1;
    logic [31:0] a1;
    logic [1:0]  exp_iss;
    logic        exp_fwd;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_pair(input logic [1:0] v, input logic [1:0] st,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0,
                          input logic [AL_W-1:0] t0, input logic [AL_W-1:0] t1);
    int n = 0;
    exp_t x;
    while (!enq_ready && n < 50) begin
      step();
      n++;
    end
    if (!enq_ready) begin
      checks++;
      errors++;
      $display("FAIL enq_ready_timeout: actual=0 required=1");
    end
    enq_valid     = v;
    enq_is_store  = st;
    enq_addr[0]   = a0;
    enq_addr[1]   = a1;
    enq_data[0]   = d0;
    enq_data[1]   = $urandom;
    enq_rd[0]     = 5'($urandom_range(0, 31));
    enq_rd[1]     = 5'($urandom_range(0, 31));
    enq_al_idx[0] = t0;
    enq_al_idx[1] = t1;
    for (int k = 0; k < 2; k++) begin
      if (v[k]) begin
        x.we   = st[k];
        x.addr = enq_addr[k][9:0];
        x.data = enq_data[k];
        x.rd   = enq_rd[k];
        x.al   = enq_al_idx[k];
        sb.push_back(x);
      end
    end
    step();
    enq_valid = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((occupancy != 0 || iss_valid != 0) && n < 40) begin
      step();
      n++;
    end
    check({name, "_drain_occ"}, 64'(occupancy), 0);
    check({name, "_drain_sb"}, 64'(sb.size()), 0);
  endtask

  // Issue monitor: every issued port must match the oldest outstanding op.
  always @(negedge clk) begin
    if (reset) begin
      if (enq_valid != 0 && !if_recall) check("enq_protocol", 64'(enq_ready), 1);
      if (iss_valid != 0) check("port_order", 64'(iss_valid == 2'b10), 0);
      for (int p = 0; p < 2; p++) begin
        if (iss_valid[p]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: actual=issue_on_port%0d required=no_issue", p);
          end else begin
            e = sb.pop_front();
            check("sb_we", 64'(iss_we[p]), 64'(e.we));
            check("sb_addr", 64'(iss_addr[p]), 64'(e.addr));
            check("sb_al", 64'(iss_al_idx[p]), 64'(e.al));
            check("sb_uses_rd", 64'(iss_uses_rd[p]), 64'(!e.we));
            if (e.we) check("sb_data", 64'(iss_data[p]), 64'(e.data));
            else      check("sb_rd", 64'(iss_rd[p]), 64'(e.rd));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"dual",      1'b1, 32'h020, 1'b0, 32'h024, 2'b11, 1'b0};
`ifdef MEM_SCHED_FWD_EN
    vecs[1] = '{"fwd",       1'b1, 32'h040, 1'b0, 32'h040, 2'b11, 1'b1};
`else
    vecs[1] = '{"fwd",       1'b1, 32'h040, 1'b0, 32'h040, 2'b01, 1'b0};
`endif
    vecs[2] = '{"st_st",     1'b1, 32'h080, 1'b1, 32'h080, 2'b01, 1'b0};
    vecs[3] = '{"ld_ld",     1'b0, 32'h0C0, 1'b0, 32'h0C0, 2'b01, 1'b0};
    vecs[4] = '{"ld_st",     1'b0, 32'h100, 1'b1, 32'h100, 2'b01, 1'b0};
    vecs[5] = '{"ld_ld_diff",1'b0, 32'h140, 1'b0, 32'h144, 2'b11, 1'b0};
    vecs[6] = '{"ld_st_diff",1'b0, 32'h180, 1'b1, 32'h040, 2'b11, 1'b0};

    // Asynchronous reset, observed before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_valid", 64'(iss_valid), 0);
    check("rst_we", 64'(iss_we), 0);
    check("rst_fwd", 64'(iss_fwd), 0);
    check("rst_uses_rd", 64'(iss_uses_rd), 0);
    check("rst_addr", 64'(iss_addr), 0);
    check("rst_data", 64'(iss_data), 0);
    check("rst_rd_al", 64'({iss_rd, iss_al_idx}), 0);
    check("rst_occ", 64'(occupancy), 0);
    check("rst_ready", 64'(enq_ready), 1);
    step();
    step();
    reset = 1'b1;

    // Pair hazard table, each from an empty queue.
    foreach (vecs[i]) begin
      enq_pair(2'b11, {vecs[i].st1, vecs[i].st0}, vecs[i].a0, vecs[i].a1,
               (i == 0) ? 32'hDEADBEEF : $urandom, AL_W'(i), AL_W'(i + 1));
      check({vecs[i].name, "_lat"}, 64'(iss_valid), 0);
      step();
      check({vecs[i].name, "_iss"}, 64'(iss_valid), 64'(vecs[i].exp_iss));
      check({vecs[i].name, "_fwd"}, 64'(iss_fwd), 64'(vecs[i].exp_fwd));
      if (i == 0) begin
        check("dual_we0", 64'(iss_we[0]), 1);
        check("dual_din0", 64'(iss_data[0]), 64'h DEADBEEF);
        check("dual_uses_rd1", 64'(iss_uses_rd[1]), 1);
      end
      if (vecs[i].exp_iss == 2'b01) begin
        step();
        check({vecs[i].name, "_second"}, 64'(iss_valid), 2'b01);
        check({vecs[i].name, "_second_fwd"}, 64'(iss_fwd), 0);
      end
      step();
      check({vecs[i].name, "_idle"}, 64'(iss_valid), 0);
      check({vecs[i].name, "_fwd_clear"}, 64'(iss_fwd), 0);
      check({vecs[i].name, "_occ"}, 64'(occupancy), 0);
    end

    // Queue fills faster than it drains when every op collides.
    enq_pair(2'b11, 2'b11, 32'h200, 32'h200, $urandom, 3'd1, 3'd2);
    enq_pair(2'b11, 2'b11, 32'h200, 32'h200, $urandom, 3'd3, 3'd4);
    check("fill_occ", 64'(occupancy), 3);
    check("fill_ready", 64'(enq_ready), 0);
    check("fill_single", 64'(iss_valid), 2'b01);
    wait_drain("fill");

    // Streaming with random types and colliding addresses wraps the pointers.
    for (int k = 0; k < 5; k++) begin
      enq_pair(2'b11, 2'($urandom_range(0, 3)),
               32'h300 + 32'(4 * $urandom_range(0, 1)),
               32'h300 + 32'(4 * $urandom_range(0, 1)),
               $urandom, AL_W'(2 * k), AL_W'(2 * k + 1));
    end
    wait_drain("wrap");

    // Mid-traffic reset clears issue outputs immediately.
    enq_pair(2'b11, 2'b00, 32'h010, 32'h014, 32'h0, 3'd1, 3'd2);
    enq_pair(2'b01, 2'b00, 32'h018, 32'h0, 32'h0, 3'd3, 3'd0);
    check("mid_busy", 64'(iss_valid), 2'b11);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(iss_valid), 0);
    check("mid_rst_we_fwd", 64'({iss_we, iss_fwd, iss_uses_rd}), 0);
    check("mid_rst_occ", 64'(occupancy), 0);
    check("mid_rst_ready", 64'(enq_ready), 1);
    sb.delete();
    step();
    reset = 1'b1;
    enq_pair(2'b01, 2'b00, 32'h010, 32'h0, 32'h0, 3'd4, 3'd0);
    check("post_rst_lat", 64'(iss_valid), 0);
    step();
    check("post_rst_iss", 64'(iss_valid), 2'b01);
    check("post_rst_we", 64'(iss_we[0]), 0);
    step();

    // Recall squashes the younger suffix [7, 1) = tags 7 and 0.
    enq_pair(2'b11, 2'b00, 32'h100, 32'h100, 32'h0, 3'd5, 3'd6);
    check("rc_occ2", 64'(occupancy), 2);
    enq_pair(2'b11, 2'b00, 32'h100, 32'h100, 32'h0, 3'd7, 3'd0);
    check("rc_first", 64'(iss_al_idx[0]), 5);
    check("rc_occ3", 64'(occupancy), 3);
    if_recall = 1'b1;
    new_front = 3'd7;
    back      = 3'd1;
    void'(sb.pop_back());
    void'(sb.pop_back());
    step();
    if_recall = 1'b0;
    check("rc_noissue", 64'(iss_valid), 0);
    check("rc_occ_after", 64'(occupancy), 1);
    step();
    check("rc_next", 64'(iss_valid), 2'b01);
    check("rc_next_tag", 64'(iss_al_idx[0]), 6);
    step();
    check("rc_empty", 64'(occupancy), 0);

    // Empty interval: nothing squashed, issue held, enqueue dropped.
    enq_pair(2'b10, 2'b00, 32'h0, 32'h140, 32'h0, 3'd0, 3'd2);
    check("ei_occ", 64'(occupancy), 1);
    if_recall     = 1'b1;
    new_front     = 3'd3;
    back          = 3'd3;
    enq_valid     = 2'b11;
    enq_is_store  = 2'b00;
    step();
    if_recall = 1'b0;
    enq_valid = '0;
    check("ei_noissue", 64'(iss_valid), 0);
    check("ei_occ_kept", 64'(occupancy), 1);
    step();
    check("ei_issue", 64'(iss_valid), 2'b01);
    check("ei_tag", 64'(iss_al_idx[0]), 2);
    wait_drain("ei");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
